// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed driver for a common-anode seven-segment display.
// A 32-bit (4*DIGITS) hex value with decimal-point and blanking masks is
// captured on a load strobe and swapped into the displayed copy only at a
// frame boundary, so a frame never mixes old and new digits. Each digit slot
// begins with a short all-dark gap to suppress ghosting between digits.
module seg7_scan #(
   parameter int DIGITS     = 8,
   parameter int SCAN_DIV   = 100000,
   parameter int GAP_CYCLES = 2000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic [DIGITS-1:0]     blank_mask,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done,
   output logic                  update_pending
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0:    hex_to_seg = 7'h40;
         4'h1:    hex_to_seg = 7'h79;
         4'h2:    hex_to_seg = 7'h24;
         4'h3:    hex_to_seg = 7'h30;
         4'h4:    hex_to_seg = 7'h19;
         4'h5:    hex_to_seg = 7'h12;
         4'h6:    hex_to_seg = 7'h02;
         4'h7:    hex_to_seg = 7'h78;
         4'h8:    hex_to_seg = 7'h00;
         4'h9:    hex_to_seg = 7'h10;
         4'hA:    hex_to_seg = 7'h08;
         4'hB:    hex_to_seg = 7'h03;
         4'hC:    hex_to_seg = 7'h46;
         4'hD:    hex_to_seg = 7'h21;
         4'hE:    hex_to_seg = 7'h06;
         default: hex_to_seg = 7'h0E;
      endcase
   endfunction

   logic [CW-1:0]         cnt;
   logic [IW-1:0]         idx;
   logic                  running;
   logic [4*DIGITS-1:0]   sh_data;
   logic [DIGITS-1:0]     sh_dp;
   logic [DIGITS-1:0]     sh_blank;
   logic [4*DIGITS-1:0]   pd_data;
   logic [DIGITS-1:0]     pd_dp;
   logic [DIGITS-1:0]     pd_blank;
   logic                  pend_valid;
   logic                  frame_done_q;

   logic                  slot_end;
   logic                  frame_end;
   logic                  in_gap;
   logic                  lit;
   logic [3:0]            nibble;

   assign slot_end  = (cnt == CNT_MAX);
   assign frame_end = slot_end && (idx == IDX_MAX);

   // Gap phase occupies the first GAP_CYCLES counts of every slot; with no gap
   // the anode switches straight from one digit to the next.
   generate
      if (GAP_CYCLES == 0) begin : g_no_gap
         assign in_gap = 1'b0;
      end else begin : g_gap
         localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES);
         assign in_gap = (cnt < GAP_END);
      end
   endgenerate

   // Slot counter and digit index; idx wrapping to 0 marks a new frame.
   // NOTE: sequential state always uses non-blocking (<=) so every register
   // samples the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         idx     <= '0;
         running <= 1'b0;
      end else begin
         running <= 1'b1;
         if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Pending/shadow handoff: loads park in pending, the frame boundary
   // promotes them; a load on the boundary cycle goes straight to shadow.
   // NOTE: these data registers are reset on purpose -- they are directly
   // visible on the display, and a reset must discard any parked load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_data    <= '0;
         sh_dp      <= '0;
         sh_blank   <= '0;
         pd_data    <= '0;
         pd_dp      <= '0;
         pd_blank   <= '0;
         pend_valid <= 1'b0;
      end else if (frame_end && load) begin
         sh_data    <= data;
         sh_dp      <= dp_mask;
         sh_blank   <= blank_mask;
         pend_valid <= 1'b0;
      end else if (load) begin
         pd_data    <= data;
         pd_dp      <= dp_mask;
         pd_blank   <= blank_mask;
         pend_valid <= 1'b1;
      end else if (frame_end && pend_valid) begin
         sh_data    <= pd_data;
         sh_dp      <= pd_dp;
         sh_blank   <= pd_blank;
         pend_valid <= 1'b0;
      end
   end

   // frame_done is high during the first cycle of each frame after the first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_done_q <= 1'b0;
      else        frame_done_q <= frame_end;
   end

   assign frame_done     = frame_done_q;
   assign update_pending = pend_valid;

   assign nibble = sh_data[int'(idx)*4 +: 4];
   // The display stays dark until the first edge after reset release.
   assign lit    = running && !in_gap && !sh_blank[idx];

   // Output decode from registered state only.
   // NOTE: every output gets a default before the conditional update, so no
   // path through this block leaves a value held (which would infer a latch).
   always_comb begin
      an  = '1;
      seg = 7'h7F;
      dp  = 1'b1;
      if (lit) begin
         an[idx] = 1'b0;
         seg     = hex_to_seg(nibble);
         dp      = ~sh_dp[idx];
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized and directed stimulus for seg7_scan, checked every
// cycle against a frame-level model (time since reset -> slot/phase, plus the
// pending/shadow handoff rules).
module tb_seg7_scan;

   localparam int D  = 8;
   localparam int S  = 4;
   localparam int G  = 1;
   localparam int FR = D * S;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load = 1'b0;
   logic [31:0]   data = '0;
   logic [7:0]    dp_mask = '0;
   logic [7:0]    blank_mask = '0;
   logic [7:0]    an;
   logic [6:0]    seg;
   logic          dp;
   logic          frame_done;
   logic          update_pending;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state.
   int            t;
   logic [31:0]   m_sh_data, m_pd_data;
   logic [7:0]    m_sh_dp, m_sh_bl, m_pd_dp, m_pd_bl;
   bit            m_pv, m_fd;

   logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan #(.DIGITS(D), .SCAN_DIV(S), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_mask(dp_mask),
      .blank_mask(blank_mask), .an(an), .seg(seg), .dp(dp),
      .frame_done(frame_done), .update_pending(update_pending)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      t = 0;
      m_sh_data = '0; m_sh_dp = '0; m_sh_bl = '0;
      m_pd_data = '0; m_pd_dp = '0; m_pd_bl = '0;
      m_pv = 1'b0; m_fd = 1'b0;
   endtask

   // Apply one rising edge to the model using the inputs present at that edge.
   task automatic model_edge();
      bit boundary;
      if (!rst_n) begin
         model_reset();
      end else begin
         boundary = ((t % FR) == FR - 1);
         if (load && boundary) begin
            m_sh_data = data; m_sh_dp = dp_mask; m_sh_bl = blank_mask; m_pv = 1'b0;
         end else if (load) begin
            m_pd_data = data; m_pd_dp = dp_mask; m_pd_bl = blank_mask; m_pv = 1'b1;
         end else if (boundary && m_pv) begin
            m_sh_data = m_pd_data; m_sh_dp = m_pd_dp; m_sh_bl = m_pd_bl; m_pv = 1'b0;
         end
         m_fd = boundary;
         t++;
      end
   endtask

   task automatic compare(input string tag);
      int         ph, dig;
      bit         lit;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic [3:0] nib;
      ph  = t % S;
      dig = (t / S) % D;
      lit = rst_n && (ph >= G) && !m_sh_bl[dig];
      nib = m_sh_data[dig*4 +: 4];
      e_an  = lit ? ~(8'h01 << dig) : 8'hFF;
      e_seg = lit ? seg_tab[nib] : 7'h7F;
      e_dp  = lit ? ~m_sh_dp[dig] : 1'b1;
      vectors++;
      if ({an, seg, dp, frame_done, update_pending} !== {e_an, e_seg, e_dp, m_fd, m_pv}) begin
         miscompares++;
         $display("FAIL %s t=%0d: got an=%h seg=%h dp=%b fd=%b up=%b, want an=%h seg=%h dp=%b fd=%b up=%b",
                  tag, t, an, seg, dp, frame_done, update_pending, e_an, e_seg, e_dp, m_fd, m_pv);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic pulse_load(input logic [31:0] d, input logic [7:0] dpm, input logic [7:0] bm,
                             input string tag);
      data = d; dp_mask = dpm; blank_mask = bm; load = 1'b1;
      step(tag);
      load = 1'b0;
   endtask

   // Step until the next rising edge is the frame boundary.
   task automatic to_boundary(input string tag);
      while ((t % FR) != FR - 1) step(tag);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      run(3, "reset_hold");
      #1 rst_n = 1'b1;
      run(2 * FR, "reset_run");
   endtask

   task automatic test_load();
      run(5, "load_pre");
      pulse_load(32'h89AB_CDEF, 8'h01, 8'h00, "load_mid");
      run(2 * FR, "load_frames");
   endtask

   task automatic test_double_load();
      run(3, "dbl_pre");
      pulse_load(32'h1234_5678, 8'h00, 8'h00, "dbl_first");
      run(4, "dbl_gap");
      pulse_load(32'h8765_4321, 8'h00, 8'h00, "dbl_second");
      run(2 * FR, "dbl_frames");
   endtask

   task automatic test_boundary_load();
      run(3, "bnd_pre");
      to_boundary("bnd_seek");
      pulse_load(32'h0000_0005, 8'h00, 8'h00, "bnd_load");
      // First ON cycle of digit 0 in the new frame.
      step("bnd_on");
      vectors++;
      if (seg !== 7'h12 || update_pending !== 1'b0 || an !== 8'hFE) begin
         miscompares++;
         $display("FAIL bnd_digit0: got seg=%h up=%b an=%h, want seg=12 up=0 an=fe",
                  seg, update_pending, an);
      end
      run(FR, "bnd_frame");
   endtask

   task automatic test_blank();
      pulse_load(32'hFEDC_BA98, 8'hA5, 8'h80, "blank_load");
      run(3 * FR, "blank_frames");
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0)
            pulse_load($urandom, 8'($urandom), 8'($urandom_range(0, 3) == 0 ? $urandom : 0), "rand_load");
         else
            step("rand_run");
      end
   endtask

   task automatic test_reset_mid();
      if ((t % FR) == FR - 1) step("rmid_avoid");
      pulse_load(32'h7777_7777, 8'hFF, 8'h00, "rmid_load");
      run(2, "rmid_wait");
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare("rmid_async");
      run(2, "rmid_hold");
      #1 rst_n = 1'b1;
      run(3 * FR, "rmid_after");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load();
      test_double_load();
      test_boundary_load();
      test_blank();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
